// File: rtl/data_ram_responder_way0.sv
// data_ram_responder_way0: latency-configurable data RAM responder for the way0 FU_Register data port.
// Ports: clk, reset (async, active-high); readAddr_i/writeAddr_i (nonzero = request),
// writeData_i, writeMask_i (halfword enables) in; readData_o, dataOk_o, writeState_o out.
// Define DRAM_RANGE_CHECK_EN to add accessFault_o (out-of-range index flag).
module data_ram_responder_way0 #(
  parameter int DEPTH = 1024,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] readAddr_i,
  input  logic [31:0] writeAddr_i,
  input  logic [63:0] writeData_i,
  input  logic [3:0]  writeMask_i,
  output logic [63:0] readData_o,
  output logic        dataOk_o,
  output logic [2:0]  writeState_o
`ifdef DRAM_RANGE_CHECK_EN
  ,
  output logic        accessFault_o
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = LATENCY > 1 ? 4'(LATENCY - 2) : 4'd0;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t state;
  logic [3:0] cnt;
  logic [28:0] r_idx, w_idx, a_ridx, a_widx;
  logic [63:0] w_data, a_data, r_word, r_merged;
  logic [3:0] w_mask, a_mask;
  logic rd, wr, a_rd, a_wr, idle, req, go, r_ok, w_in, w_ok, release_req;
  logic [63:0] mem [DEPTH];
  logic unused_bits;
  assign unused_bits = ^{readAddr_i[2:0], writeAddr_i[2:0]};
  assign idle = state == IDLE;
  assign req = |readAddr_i || |writeAddr_i;
  // With LATENCY=1 the access happens on the accepting edge, so BUSY is skipped
  // and the operands come straight from the inputs instead of the latches.
  assign go = idle ? req && LATENCY == 1 : state == BUSY && cnt == 4'd0;
  assign a_rd = idle ? |readAddr_i : rd;
  assign a_wr = idle ? |writeAddr_i : wr;
  assign a_ridx = idle ? readAddr_i[31:3] : r_idx;
  assign a_widx = idle ? writeAddr_i[31:3] : w_idx;
  assign a_data = idle ? writeData_i : w_data;
  assign a_mask = idle ? writeMask_i : w_mask;
  assign r_ok = a_ridx < 29'(DEPTH);
  assign w_in = a_widx < 29'(DEPTH);
  assign w_ok = a_wr && w_in;
  assign r_word = mem[a_ridx[AW-1:0]];
  // Read sees the write of the same transaction: forward enabled halfwords.
  for (genvar h = 0; h < 4; h++) begin : g_merge
    assign r_merged[16*h +: 16] = (w_ok && a_widx == a_ridx && a_mask[h]) ? a_data[16*h +: 16] : r_word[16*h +: 16];
  end
  assign release_req = (!rd || readAddr_i == 32'd0) && (!wr || writeAddr_i == 32'd0);
  always_ff @(posedge clk) begin
    if (go && w_ok)
      for (int k = 0; k < 4; k++)
        if (a_mask[k]) mem[a_widx[AW-1:0]][16*k +: 16] <= a_data[16*k +: 16];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt <= 4'd0;
      rd <= 1'b0;
      wr <= 1'b0;
      r_idx <= '0;
      w_idx <= '0;
      w_data <= '0;
      w_mask <= '0;
      readData_o <= '0;
      dataOk_o <= 1'b0;
      writeState_o <= 3'b000;
    end else begin
      if (idle && req) begin
        rd <= |readAddr_i;
        wr <= |writeAddr_i;
        r_idx <= readAddr_i[31:3];
        w_idx <= writeAddr_i[31:3];
        w_data <= writeData_i;
        w_mask <= writeMask_i;
        cnt <= CNT_INIT;
      end
      if (go) begin
        state <= DONE;
        readData_o <= (a_rd && r_ok) ? r_merged : 64'd0;
        dataOk_o <= a_rd;
        writeState_o <= {3{a_wr}};
      end else if (idle && req) begin
        state <= BUSY;
      end else if (state == BUSY) begin
        cnt <= cnt - 4'd1;
      end else if (state == DONE && release_req) begin
        state <= IDLE;
        readData_o <= '0;
        dataOk_o <= 1'b0;
        writeState_o <= 3'b000;
      end
    end
  end
`ifdef DRAM_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) accessFault_o <= 1'b0;
    else if (go) accessFault_o <= (a_rd && !r_ok) || (a_wr && !w_in);
    else if (state == DONE && release_req) accessFault_o <= 1'b0;
  end
`endif
endmodule

// File: tb/tb_data_ram_responder_way0.sv
// tb_data_ram_responder_way0: table-driven scoreboard bench with a LATENCY=1 and a LATENCY=4 instance.
module tb_data_ram_responder_way0;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  logic [31:0] ra [2];
  logic [31:0] wa [2];
  logic [63:0] wd [2];
  logic [3:0] wm [2];
  logic [63:0] rdat [2];
  logic ok [2];
  logic [2:0] ws [2];
`ifdef DRAM_RANGE_CHECK_EN
  logic flt [2];
`endif
  data_ram_responder_way0 #(.DEPTH(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .reset(reset),
    .readAddr_i(ra[0]), .writeAddr_i(wa[0]), .writeData_i(wd[0]), .writeMask_i(wm[0]),
    .readData_o(rdat[0]), .dataOk_o(ok[0]), .writeState_o(ws[0])
`ifdef DRAM_RANGE_CHECK_EN
    , .accessFault_o(flt[0])
`endif
  );
  data_ram_responder_way0 #(.DEPTH(1024), .LATENCY(4)) u_l4 (
    .clk(clk), .reset(reset),
    .readAddr_i(ra[1]), .writeAddr_i(wa[1]), .writeData_i(wd[1]), .writeMask_i(wm[1]),
    .readData_o(rdat[1]), .dataOk_o(ok[1]), .writeState_o(ws[1])
`ifdef DRAM_RANGE_CHECK_EN
    , .accessFault_o(flt[1])
`endif
  );
  typedef struct {
    int s;
    logic [31:0] ra;
    logic [31:0] wa;
    logic [63:0] wd;
    logic [3:0] wm;
    logic eok;
    logic [2:0] ews;
    logic [63:0] ed;
    logic ef;
  } vec_t;
  vec_t vecs [13];
  vec_t exp_q [$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v);
    vec_t e;
    int n;
    ra[v.s] = v.ra;
    wa[v.s] = v.wa;
    wd[v.s] = v.wd;
    wm[v.s] = v.wm;
    exp_q.push_back(v);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ok[v.s] && ws[v.s] == 3'b000 && n < 20);
    e = exp_q.pop_front();
    chk("latency", 64'(n), v.s ? 64'd4 : 64'd1);
    chk("dataOk", 64'(ok[v.s]), 64'(e.eok));
    chk("writeState", 64'(ws[v.s]), 64'(e.ews));
    chk("readData", rdat[v.s], e.ed);
`ifdef DRAM_RANGE_CHECK_EN
    chk("accessFault", 64'(flt[v.s]), 64'(e.ef));
`endif
    @(posedge clk);
    #1;
    chk("hold_data", rdat[v.s], e.ed);
    chk("hold_flags", 64'({ok[v.s], ws[v.s]}), 64'({e.eok, e.ews}));
    ra[v.s] = 32'd0;
    wa[v.s] = 32'd0;
    @(posedge clk);
    #1;
    chk("fall_data", rdat[v.s], 64'd0);
    chk("fall_flags", 64'({ok[v.s], ws[v.s]}), 64'd0);
  endtask
  initial begin
    int n;
    vecs[0]  = '{0, 32'h0,    32'h10,   64'h1122334455667788, 4'hF, 1'b0, 3'b111, 64'h0, 1'b0};
    vecs[1]  = '{0, 32'h10,   32'h0,    64'h0,                4'h0, 1'b1, 3'b000, 64'h1122334455667788, 1'b0};
    vecs[2]  = '{0, 32'h0,    32'h20,   64'h0,                4'hF, 1'b0, 3'b111, 64'h0, 1'b0};
    vecs[3]  = '{0, 32'h0,    32'h20,   64'hFFFFFFFFFFFFFFFF, 4'h5, 1'b0, 3'b111, 64'h0, 1'b0};
    vecs[4]  = '{0, 32'h20,   32'h0,    64'h0,                4'h0, 1'b1, 3'b000, 64'h0000FFFF0000FFFF, 1'b0};
    vecs[5]  = '{0, 32'h2000, 32'h0,    64'h0,                4'h0, 1'b1, 3'b000, 64'h0, 1'b1};
    vecs[6]  = '{0, 32'h0,    32'h2000, 64'hDEAD,             4'hF, 1'b0, 3'b111, 64'h0, 1'b1};
    vecs[7]  = '{0, 32'h0,    32'h10,   64'h0,                4'h0, 1'b0, 3'b111, 64'h0, 1'b0};
    vecs[8]  = '{0, 32'h17,   32'h0,    64'h0,                4'h0, 1'b1, 3'b000, 64'h1122334455667788, 1'b0};
    vecs[9]  = '{0, 32'h10,   32'h18,   64'h77,               4'hF, 1'b1, 3'b111, 64'h1122334455667788, 1'b0};
    vecs[10] = '{1, 32'h30,   32'h30,   64'hAB,               4'hF, 1'b1, 3'b111, 64'hAB, 1'b0};
    vecs[11] = '{1, 32'h0,    32'h40,   64'h5555,             4'hF, 1'b0, 3'b111, 64'h0, 1'b0};
    vecs[12] = '{1, 32'h40,   32'h0,    64'h0,                4'h0, 1'b1, 3'b000, 64'h5555, 1'b0};
    for (int i = 0; i < 2; i++) begin
      ra[i] = 32'd0;
      wa[i] = 32'd0;
      wd[i] = 64'd0;
      wm[i] = 4'd0;
    end
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("idle", rdat[0] | rdat[1] | 64'({ok[0], ws[0], ok[1], ws[1]}), 64'd0);
    end
    for (int i = 0; i < 12; i++) run(vecs[i]);
    // reset during BUSY of a write to 0x40: write must not commit
    wa[1] = 32'h40;
    wd[1] = 64'hDEAD;
    wm[1] = 4'hF;
    @(posedge clk);
    #1;
    chk("busy_c1", 64'({ok[1], ws[1]}), 64'd0);
    @(posedge clk);
    #1;
    chk("busy_c2", 64'({ok[1], ws[1]}), 64'd0);
    reset = 1'b1;
    #1;
    chk("rst_busy", rdat[1] | 64'({ok[1], ws[1]}), 64'd0);
    wa[1] = 32'd0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    run(vecs[12]);
    // reset in DONE clears outputs at once, held request is re-accepted
    ra[1] = 32'h30;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ok[1] && n < 20);
    chk("done_lat", 64'(n), 64'd4);
    chk("done_data", rdat[1], 64'hAB);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_done_ok", 64'(ok[1]), 64'd0);
    chk("rst_done_data", rdat[1], 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ok[1] && n < 20);
    chk("reaccept_lat", 64'(n), 64'd4);
    chk("reaccept_data", rdat[1], 64'hAB);
    ra[1] = 32'd0;
    @(posedge clk);
    #1;
    chk("reaccept_fall", rdat[1] | 64'(ok[1]), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
